mul_unit_scheduler: RTL and testbench

Round-robin scheduler that shares the single sequential 32x32 signed Booth multiplier among `NREQ` multiply reservation-station entries in the Tomasulo core. It grants one ready entry at a time, launches the multiplier, and waits for completion. It then broadcasts the selected product half with the entry's tag on the common data bus (CDB) through a valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/mul_unit_scheduler_if.sv | 37 +++
 rtl/mul_unit_scheduler.sv | 148 ++++++++++++++
 tb/tb_mul_unit_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_scheduler_if.sv
// Request, multiplier and CDB bundle for mul_unit_scheduler.
// slave = scheduler side, master = reservation stations / multiplier / CDB.
interface mul_unit_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4
);
    logic [NREQ-1:0]       req;
    logic [32*NREQ-1:0]    req_a;
    logic [32*NREQ-1:0]    req_b;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic [NREQ-1:0]       req_hi;
    logic [NREQ-1:0]       grant;
    logic                  mul_start;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_busy;
    logic [31:0]           mul_lo;
    logic [31:0]           mul_hi;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [31:0]           cdb_data;
    logic                  cdb_ready;

    modport slave (
        input  req, req_a, req_b, req_tag, req_hi,
        input  mul_busy, mul_lo, mul_hi, cdb_ready,
        output grant, mul_start, mul_a, mul_b,
        output cdb_valid, cdb_tag, cdb_data
    );

    modport master (
        output req, req_a, req_b, req_tag, req_hi,
        output mul_busy, mul_lo, mul_hi, cdb_ready,
        input  grant, mul_start, mul_a, mul_b,
        input  cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/mul_unit_scheduler.sv
// Round-robin scheduler sharing one sequential multiplier among RS entries.
// Define MUL_SCHED_FLUSH_EN to add the flush port and kill flag.
module mul_unit_scheduler #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MUL_SCHED_FLUSH_EN
    input  logic flush,
`endif
    mul_unit_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             hi_q, hi_d;
    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    cand;
    logic             killed;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // First requester at or after rr, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        cand  = rr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
    end

`ifdef MUL_SCHED_FLUSH_EN
    logic kill_q, kill_d;

    assign killed = kill_q | flush;

    always_comb begin
        kill_d = kill_q;
        if (flush && (state_q == S_ISSUE || state_q == S_ARM ||
                      state_q == S_RUN))
            kill_d = 1'b1;
        if (state_d == S_IDLE)
            kill_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) kill_q <= 1'b0;
        else          kill_q <= kill_d;
    end
`else
    assign killed = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        hi_d    = hi_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (found && !bus.mul_busy) begin
                    sel_d   = pick;
                    a_d     = bus.req_a[32*int'(pick) +: 32];
                    b_d     = bus.req_b[32*int'(pick) +: 32];
                    tag_d   = bus.req_tag[TAG_W*int'(pick) +: TAG_W];
                    hi_d    = bus.req_hi[pick];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rr_d    = wrap_inc(sel_q);
                state_d = S_ARM;
            end
            S_ARM: begin
                if (bus.mul_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.mul_busy) begin
                    if (killed) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = hi_q ? bus.mul_hi : bus.mul_lo;
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (killed || bus.cdb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            hi_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant     = (state_q == S_ISSUE) ? (NREQ'(1) << sel_q) : '0;
    assign bus.mul_start = (state_q == S_ISSUE);
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.cdb_valid = (state_q == S_RESULT);
    assign bus.cdb_tag   = tag_q;
    assign bus.cdb_data  = data_q;
endmodule

// File: tb/tb_mul_unit_scheduler.sv
// Directed bench for mul_unit_scheduler with a 34-cycle multiplier model.
// Flush checks are compiled in when MUL_SCHED_FLUSH_EN is defined.
module tb_mul_unit_scheduler;
    localparam int NREQ  = 4;
    localparam int TAG_W = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
`ifdef MUL_SCHED_FLUSH_EN
    logic flush   = 1'b0;
`endif

    mul_unit_scheduler_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

    mul_unit_scheduler #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef MUL_SCHED_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: busy from the cycle after start for 34 cycles
    bit          busy_m = 1'b0;
    int          cnt_m  = 0;
    logic [63:0] prod_m = '0;

    always @(posedge clk) begin
        if (bus.mul_start && !busy_m) begin
            busy_m <= 1'b1;
            cnt_m  <= 33;
            prod_m <= 64'($signed(bus.mul_a)) * 64'($signed(bus.mul_b));
        end else if (busy_m) begin
            if (cnt_m == 0) busy_m <= 1'b0;
            else            cnt_m  <= cnt_m - 1;
        end
    end

    assign bus.mul_busy = busy_m;
    assign bus.mul_lo   = prod_m[31:0];
    assign bus.mul_hi   = prod_m[63:32];

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]  rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  rr_t [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic [31:0] rr_d [5] = '{32'd200, 32'd300, 32'd400, 32'd500, 32'd200};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_entry(input int i, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag,
                             input logic hi);
        bus.req_a[32*i +: 32]      = a;
        bus.req_b[32*i +: 32]      = b;
        bus.req_tag[TAG_W*i +: 4]  = tag;
        bus.req_hi[i]              = hi;
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int n = 0;
        while (bus.grant == '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        g = bus.grant;
    endtask

    task automatic wait_valid(output logic v);
        int n = 0;
        while (!bus.cdb_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        v = bus.cdb_valid;
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_grant"}, bus.grant, 0);
        chk({pfx, "_start"}, bus.mul_start, 0);
        chk({pfx, "_mul_a"}, bus.mul_a, 0);
        chk({pfx, "_mul_b"}, bus.mul_b, 0);
        chk({pfx, "_valid"}, bus.cdb_valid, 0);
        chk({pfx, "_tag"}, bus.cdb_tag, 0);
        chk({pfx, "_data"}, bus.cdb_data, 0);
    endtask

    // Full-latency single operation; call with the DUT in IDLE at a negedge
    task automatic run_op(input int i, input logic [31:0] exp_d,
                          input logic [3:0] exp_t);
        logic [3:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        bus.req[i] = 1'b1;
        @(negedge clk);
        chk("op_grant", bus.grant, oh);
        chk("op_start", bus.mul_start, 1);
        bus.req[i] = 1'b0;
        repeat (35) @(negedge clk);
        chk("op_valid_t36", bus.cdb_valid, 0);
        @(negedge clk);
        chk("op_valid_t37", bus.cdb_valid, 1);
        chk("op_tag", bus.cdb_tag, exp_t);
        chk("op_data", bus.cdb_data, exp_d);
        @(negedge clk);
        chk("op_valid_drop", bus.cdb_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic       v;
        bit         ok;
        int         n;

        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.req_hi    = '0;
        bus.cdb_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        set_entry(0, 32'd7,        32'hFFFFFFFD, 4'd5, 1'b0);
        set_entry(1, 32'hFFFF0000, 32'h00010000, 4'd6, 1'b1);
        set_entry(2, 32'h80000000, 32'h80000000, 4'd9, 1'b1);
        set_entry(3, 32'h80000000, 32'h80000000, 4'd3, 1'b0);
        @(negedge clk);

        run_op(0, 32'hFFFFFFEB, 4'd5);
        run_op(1, 32'hFFFFFFFF, 4'd6);
        run_op(2, 32'h40000000, 4'd9);
        run_op(3, 32'h00000000, 4'd3);

        for (int i = 0; i < 4; i++)
            set_entry(i, 32'(i + 2), 32'd100, 4'(4'hA + i), 1'b0);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rr_grant", g, rr_g[k]);
            if (k == 4) bus.req = '0;
            wait_valid(v);
            chk("rr_valid", v, 1);
            chk("rr_tag", bus.cdb_tag, rr_t[k]);
            chk("rr_data", bus.cdb_data, rr_d[k]);
            @(negedge clk);
        end

        set_entry(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 1'b0);
        bus.cdb_ready = 1'b0;
        bus.req[1]    = 1'b1;
        wait_grant(g);
        chk("bp_grant", g, 4'b0010);
        bus.req = 4'b0100;
        wait_valid(v);
        chk("bp_valid", v, 1);
        chk("bp_tag", bus.cdb_tag, 4'd7);
        chk("bp_data", bus.cdb_data, 32'd1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.cdb_valid && bus.cdb_tag == 4'd7 &&
                  bus.cdb_data == 32'd1 && bus.grant == '0))
                ok = 1'b0;
        end
        chk("bp_hold", ok, 1);
        bus.cdb_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_grant", bus.grant, 0);
        chk("bp_idle_valid", bus.cdb_valid, 0);
        @(negedge clk);
        chk("bp_next_grant", bus.grant, 4'b0100);
        bus.req = '0;
        wait_valid(v);
        chk("bp_next_data", bus.cdb_data, 32'd400);
        chk("bp_next_tag", bus.cdb_tag, 4'hC);
        @(negedge clk);

        bus.req[3] = 1'b1;
        @(negedge clk);
        chk("rst_op_grant", bus.grant, 4'b1000);
        bus.req = '0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        bus.req[0] = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        n  = 0;
        while (busy_m && n < 60) begin
            if (bus.grant != '0 || bus.cdb_valid) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("rst_block", ok && !busy_m, 1);
        wait_grant(g);
        chk("rst_regrant", g, 4'b0001);
        bus.req = '0;
        wait_valid(v);
        chk("rst_data", bus.cdb_data, 32'd200);
        chk("rst_tag", bus.cdb_tag, 4'hA);
        @(negedge clk);

`ifdef MUL_SCHED_FLUSH_EN
        bus.req[1] = 1'b1;
        @(negedge clk);
        chk("fl_grant0", bus.grant, 4'b0010);
        bus.req = 4'b0100;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ok = 1'b1;
        n  = 0;
        while (bus.grant == '0 && n < 80) begin
            if (bus.cdb_valid) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("fl_novalid", ok, 1);
        chk("fl_next_grant", bus.grant, 4'b0100);
        chk("fl_busy_low", busy_m, 0);
        bus.req = '0;
        wait_valid(v);
        chk("fl_next_data", bus.cdb_data, 32'd400);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
